keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end for the microwave oven. Scans a 4-row × 3-column telephone-style keypad, synchronises and debounces the column returns, and drives the one-hot `keypad[9:0]` bus consumed by the oven's keypad input stage. It also provides the `*` and `#` keys as separate levels and a one-cycle strobe for each accepted press. It is the producing end of the `keypad[9:0]` interface.

## Interface
Parameters:
- `SCAN_DIV`, default 4: clock cycles each row is driven (dwell); legal range ≥ 4.
- `DEBOUNCE`, default 3: consecutive identical frames required to accept a press or a release; legal range ≥ 1.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `col_n`  in  3  column returns, active low, externally pulled up; asynchronous to `clock`.
- `row_n`  out  4  row drives, active low, exactly one bit low at any time.
- `keypad`  out  10  one-hot digit 0–9 currently accepted; all zero when none.
- `star`  out  1  `*` key accepted and held.
- `hash`  out  1  `#` key accepted and held.
- `new_key`  out  1  one-cycle pulse on the cycle an accepted press first appears on the outputs.

## Operation
- **Synchroniser:** `col_n` passes through two flops before use.
- **Row scan:**
  - A row counter cycles rows 0→1→2→3→0. Each row is held for `SCAN_DIV` cycles by a dwell counter (0..SCAN_DIV-1).
  - `row_n` = ~(1<<row).
  - The synchronised columns are sampled on dwell count SCAN_DIV-1 into a 12-bit frame snapshot, with bit index = row*3+col.
- **Key map:**
  - row0 = 1,2,3
  - row1 = 4,5,6
  - row2 = 7,8,9
  - row3 = *,0,#
- **Frame result:** evaluated after the row-3 sample.
  - Exactly one snapshot bit set: result is that key.
  - Zero bits set, or two or more bits set: result is NONE. Multi-key frames are never decoded.
- **Debounce FSM:** states IDLE, CHECK, HELD. Holds a candidate key register and a frame counter of width clog2(DEBOUNCE+1).
  - IDLE:
    - result = key k: candidate = k, cnt = 1, go to CHECK.
    - If DEBOUNCE = 1, go directly to HELD instead.
  - CHECK:
    - result == candidate: cnt++. When cnt reaches DEBOUNCE, go to HELD.
    - result NONE: go to IDLE.
    - result a different key: restart CHECK with the new candidate, cnt = 1.
  - HELD:
    - Outputs reflect the candidate.
    - result == candidate: cnt = 0.
    - Any other result (NONE or a different key) increments the release counter. At DEBOUNCE, clear the outputs and go to IDLE.
    - A different key must then re-qualify from IDLE.
- **Outputs on entry to HELD:**
  - digit k: `keypad` = 1<<k.
  - `*`: `star` = 1.
  - `#`: `hash` = 1.
  - `new_key` pulses for exactly one cycle.
  - At most one of `keypad`/`star`/`hash` is nonzero at any time.

## Timing
- **Reset values:** `row_n` = 4'b1110; `keypad` = 0; `star` = `hash` = `new_key` = 0. FSM in IDLE; all counters 0. All apply immediately on `clear`, without waiting for a clock edge.
- **Deassertion:** scanning restarts at row 0, dwell 0 on the first edge after `clear` deasserts.
- **Frame length:** F = 4*SCAN_DIV cycles, free-running and never stalled.
- **Column settle:** a sample reflects a row that has been driven for at least SCAN_DIV-2 cycles, which is ≥ 2 synchroniser stages.
- **Registered outputs:** outputs change on the clock edge immediately after the row-3 sample cycle of the qualifying frame.
- **Press latency:** a key stable across frames 1..DEBOUNCE appears at the end of frame DEBOUNCE.
- **Release latency:** the key clears at the end of the DEBOUNCE-th non-matching frame.
- **Mid-operation reset:** `clear` in any state, including HELD, drops all outputs at once. A held key must re-qualify after reset.
- **`new_key`:** never asserted for a release, a hold, or a reset.

## Test plan
Defaults used throughout: SCAN_DIV=4, DEBOUNCE=3, F=16.

1. **Reset/scan:** assert `clear`, then release it → `row_n` = 1110 during reset. After release, `row_n` steps 1110→1101→1011→0111 every 4 cycles. All key outputs stay 0 with no keys pressed.
2. **Clean press of '5' (row1,col1) for 8 frames:**
   - `keypad` = 10'b0000100000 after the end of frame 3.
   - `new_key` high for 1 cycle.
   - After release, `keypad` = 0 exactly 3 frames later.
3. **Bounce:** '7' present in alternating frames for 12 frames → `keypad` stays 0 and `new_key` never pulses.
4. **Multi-key:** '1' and '2' pressed together for 5 frames → no output. Then '2' is released → `keypad` = 10'b0000000010 three frames later.
5. **Special keys:**
   - `#` held 4 frames → `hash` = 1, `keypad` = 0, `new_key` pulses once.
   - `*` held 4 frames → `star` = 1.
6. **Switch and reset:**
   - '3' is HELD, then the press moves directly to '9' → `keypad` = 0 three frames later, then bit 9 set three frames after that.
   - Assert `clear` while '9' is held → outputs drop to 0 asynchronously.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix-keypad front end: scans a 4x3 keypad, synchronises and debounces the
// column returns, and drives one-hot digit, star/hash levels and a press strobe.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       star,
    output logic       hash,
    output logic       new_key
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // Returns {exactly_one_bit_set, index_of_set_bit}; multi-key frames are invalid.
    function automatic logic [4:0] frame_decode(input logic [11:0] f);
        logic [3:0] ones;
        logic [3:0] idx;
        ones = 4'd0;
        idx  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (f[i]) begin
                ones = ones + 4'd1;
                idx  = 4'(i);
            end else begin
                ones = ones;
            end
        end
        return {(ones == 4'd1), idx};
    endfunction

    // Maps a frame bit index (row*3+col) to {star, hash, keypad[9:0]}.
    function automatic logic [11:0] key_to_outputs(input logic [3:0] idx);
        logic [11:0] o;
        case (idx)
            4'd0:    o = 12'b00_0000000010;
            4'd1:    o = 12'b00_0000000100;
            4'd2:    o = 12'b00_0000001000;
            4'd3:    o = 12'b00_0000010000;
            4'd4:    o = 12'b00_0000100000;
            4'd5:    o = 12'b00_0001000000;
            4'd6:    o = 12'b00_0010000000;
            4'd7:    o = 12'b00_0100000000;
            4'd8:    o = 12'b00_1000000000;
            4'd9:    o = 12'b10_0000000000;
            4'd10:   o = 12'b00_0000000001;
            4'd11:   o = 12'b01_0000000000;
            default: o = 12'b00_0000000000;
        endcase
        return o;
    endfunction

    logic [2:0]    col_meta_r, col_sync_r;
    logic [1:0]    row_r;
    logic [DW-1:0] dwell_r;
    logic [3:0]    row_n_r;
    logic [8:0]    snap_r;
    logic          sample_s, frame_end_s;
    logic [11:0]   frame_s;
    logic [4:0]    decode_s;
    logic          res_valid_s;
    logic [3:0]    res_idx_s;
    logic [11:0]   hot_s;
    logic [CW-1:0] cnt_inc_s;

    state_t        state_r, state_s;
    logic [3:0]    cand_r, cand_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [9:0]    keypad_r, keypad_s;
    logic          star_r, star_s, hash_r, hash_s, new_key_r, new_key_s;

    // Two-flop synchroniser for the asynchronous column returns (idle high).
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            col_meta_r <= 3'b111;
            col_sync_r <= 3'b111;
        end else begin
            col_meta_r <= col_n;
            col_sync_r <= col_meta_r;
        end
    end

    assign sample_s    = (dwell_r == DWELL_LAST);
    assign frame_end_s = sample_s && (row_r == 2'd3);

    // Free-running row scan: dwell counter and one-hot active-low row drive.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            row_r   <= 2'd0;
            dwell_r <= {DW{1'b0}};
            row_n_r <= 4'b1110;
        end else if (sample_s) begin
            row_r   <= row_r + 2'd1;
            dwell_r <= {DW{1'b0}};
            row_n_r <= {row_n_r[2:0], row_n_r[3]};
        end else begin
            dwell_r <= dwell_r + DWELL_ONE;
        end
    end

    // Rows 0-2 of the snapshot; row 3 is taken live so the frame resolves on its sample edge.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            snap_r <= 9'd0;
        end else if (sample_s) begin
            case (row_r)
                2'd0:    snap_r[2:0] <= ~col_sync_r;
                2'd1:    snap_r[5:3] <= ~col_sync_r;
                2'd2:    snap_r[8:6] <= ~col_sync_r;
                default: snap_r      <= snap_r;
            endcase
        end else begin
            snap_r <= snap_r;
        end
    end

    assign frame_s     = {~col_sync_r, snap_r};
    assign decode_s    = frame_decode(frame_s);
    assign res_valid_s = decode_s[4];
    assign res_idx_s   = decode_s[3:0];
    assign hot_s       = key_to_outputs(res_idx_s);
    assign cnt_inc_s   = cnt_r + CNT_ONE;

    // Debounce next-state and output logic, evaluated once per completed frame.
    always_comb begin
        state_s   = state_r;
        cand_s    = cand_r;
        cnt_s     = cnt_r;
        keypad_s  = keypad_r;
        star_s    = star_r;
        hash_s    = hash_r;
        new_key_s = 1'b0;
        if (frame_end_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (res_valid_s) begin
                        cand_s = res_idx_s;
                        if (DEBOUNCE == 1) begin
                            state_s   = ST_HELD;
                            cnt_s     = CNT_ZERO;
                            {star_s, hash_s, keypad_s} = hot_s;
                            new_key_s = 1'b1;
                        end else begin
                            state_s = ST_CHECK;
                            cnt_s   = CNT_ONE;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (res_valid_s && (res_idx_s == cand_r)) begin
                        if (cnt_inc_s == CNT_LAST) begin
                            state_s   = ST_HELD;
                            cnt_s     = CNT_ZERO;
                            {star_s, hash_s, keypad_s} = hot_s;
                            new_key_s = 1'b1;
                        end else begin
                            cnt_s = cnt_inc_s;
                        end
                    end else if (res_valid_s) begin
                        cand_s = res_idx_s;
                        cnt_s  = CNT_ONE;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end
                ST_HELD: begin
                    // cnt counts consecutive non-matching frames while held.
                    if (res_valid_s && (res_idx_s == cand_r)) begin
                        cnt_s = CNT_ZERO;
                    end else if (cnt_inc_s == CNT_LAST) begin
                        state_s  = ST_IDLE;
                        cnt_s    = CNT_ZERO;
                        keypad_s = 10'd0;
                        star_s   = 1'b0;
                        hash_s   = 1'b0;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    cnt_s    = CNT_ZERO;
                    keypad_s = 10'd0;
                    star_s   = 1'b0;
                    hash_s   = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Debounce state, candidate, counter and registered key outputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r   <= ST_IDLE;
            cand_r    <= 4'd0;
            cnt_r     <= CNT_ZERO;
            keypad_r  <= 10'd0;
            star_r    <= 1'b0;
            hash_r    <= 1'b0;
            new_key_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cand_r    <= cand_s;
            cnt_r     <= cnt_s;
            keypad_r  <= keypad_s;
            star_r    <= star_s;
            hash_r    <= hash_s;
            new_key_r <= new_key_s;
        end
    end

    assign row_n   = row_n_r;
    assign keypad  = keypad_r;
    assign star    = star_r;
    assign hash    = hash_r;
    assign new_key = new_key_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated keypad matrix driven by a
// pressed-key mask, checked against a frame-history reference model.
module tb_keypad_scanner;

    localparam int DEB = 3;

    logic        clock = 1'b0;
    logic        clear;
    logic [2:0]  col_n;
    logic [3:0]  row_n;
    logic [9:0]  keypad;
    logic        star, hash, new_key;
    logic [11:0] pressed;

    int total = 0;
    int bad   = 0;
    int pulses;

    int   hist[$];
    int   base;
    int   held;
    logic exp_new;
    string lbl = "123456789*0#";

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(DEB)) dut (
        .clock   (clock),
        .clear   (clear),
        .col_n   (col_n),
        .row_n   (row_n),
        .keypad  (keypad),
        .star    (star),
        .hash    (hash),
        .new_key (new_key)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a pressed key shorts its column to the row being driven low.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) col_n = col_n & ~pressed[r*3 +: 3];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_result(input logic [11:0] m);
        if ($countones(m) != 1) return -1;
        for (int i = 0; i < 12; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [9:0] exp_keypad();
        byte ch;
        if (held < 0) return 10'd0;
        ch = lbl[held];
        if (ch >= "0" && ch <= "9") return 10'd1 << (ch - "0");
        return 10'd0;
    endfunction

    function automatic logic exp_star();
        return (held >= 0) && (lbl[held] == "*");
    endfunction

    function automatic logic exp_hash();
        return (held >= 0) && (lbl[held] == "#");
    endfunction

    task automatic model_reset();
        hist.delete();
        base    = 0;
        held    = -1;
        exp_new = 1'b0;
    endtask

    // A key is accepted after DEB consecutive frames naming it, counted only from
    // the last accept/release; it is released after DEB consecutive frames not naming it.
    task automatic model_step(input int r);
        int  n;
        bit  all_eq, all_ne;
        hist.push_back(r);
        n = hist.size();
        exp_new = 1'b0;
        if (n - base >= DEB) begin
            all_eq = 1'b1;
            all_ne = 1'b1;
            for (int j = n - DEB; j < n; j++) begin
                if (hist[j] != r)    all_eq = 1'b0;
                if (hist[j] == held) all_ne = 1'b0;
            end
            if (held < 0) begin
                if (r >= 0 && all_eq) begin
                    held    = r;
                    exp_new = 1'b1;
                    base    = n;
                end
            end else if (all_ne) begin
                held = -1;
                base = n;
            end
        end
    endtask

    // Runs one 16-cycle frame with mask m held; entered and left at the frame-start negedge.
    task automatic do_frame(input logic [11:0] m);
        logic [3:0] er;
        pressed = m;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                chk("keypad", {22'd0, keypad}, {22'd0, exp_keypad()});
                chk("star", {31'd0, star}, {31'd0, exp_star()});
                chk("hash", {31'd0, hash}, {31'd0, exp_hash()});
                chk("new_key", {31'd0, new_key}, {31'd0, exp_new});
            end else begin
                chk("new_key_width", {31'd0, new_key}, 32'd0);
            end
            er = 4'b0001 << (i / 4);
            er = ~er;
            chk("row_n", {28'd0, row_n}, {28'd0, er});
            if (new_key) pulses++;
            @(negedge clock);
        end
        model_step(frame_result(m));
    endtask

    task automatic align();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = row_n;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clock);
            if (prev == 4'b0111 && row_n == 4'b1110) found = 1'b1;
            prev = row_n;
        end
        chk("frame_align", {31'd0, found}, 32'd1);
    endtask

    task automatic frames(input logic [11:0] m, input int n);
        for (int f = 0; f < n; f++) do_frame(m);
    endtask

    initial begin
        logic [11:0] m, prev_m;
        int a, b, sel;

        // Reset and idle scan
        pressed = 12'd0;
        clear   = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_row_n", {28'd0, row_n}, 32'h0000000e);
        chk("rst_outs", {19'd0, keypad, star, hash, new_key}, 32'd0);
        clear = 1'b0;
        align();
        frames(12'd0, 2);

        // Clean '5' press, 8 frames, then release
        pulses = 0;
        for (int f = 1; f <= 8; f++) begin
            do_frame(12'b0000_0001_0000);
            if (f == 2) chk("t2_not_yet", {22'd0, keypad}, 32'd0);
            if (f == 3) chk("t2_key5", {22'd0, keypad}, 32'h00000020);
        end
        for (int f = 1; f <= 3; f++) begin
            do_frame(12'd0);
            if (f == 2) chk("t2_still_held", {22'd0, keypad}, 32'h00000020);
        end
        chk("t2_released", {22'd0, keypad}, 32'd0);
        do_frame(12'd0);
        chk("t2_one_pulse", pulses, 32'd1);

        // Bouncing '7'
        pulses = 0;
        for (int f = 0; f < 12; f++) do_frame((f % 2 == 0) ? 12'b0000_0100_0000 : 12'd0);
        do_frame(12'd0);
        chk("t3_no_pulse", pulses, 32'd0);
        chk("t3_no_key", {22'd0, keypad}, 32'd0);

        // '1' and '2' together, then '2' released leaving '1'
        frames(12'b0000_0000_0011, 5);
        chk("t4_multi", {22'd0, keypad}, 32'd0);
        frames(12'b0000_0000_0001, 3);
        chk("t4_key1", {22'd0, keypad}, 32'h00000002);
        frames(12'd0, 4);

        // Special keys
        pulses = 0;
        frames(12'b1000_0000_0000, 4);
        chk("t5_hash", {30'd0, hash, star}, 32'd2);
        chk("t5_hash_kp", {22'd0, keypad}, 32'd0);
        frames(12'd0, 4);
        chk("t5_hash_pulse", pulses, 32'd1);
        frames(12'b0010_0000_0000, 4);
        chk("t5_star", {30'd0, hash, star}, 32'd1);
        frames(12'd0, 4);

        // '3' held, slide to '9'
        frames(12'b0000_0000_0100, 4);
        chk("t6_key3", {22'd0, keypad}, 32'h00000008);
        frames(12'b0001_0000_0000, 3);
        chk("t6_switch_gap", {22'd0, keypad}, 32'd0);
        frames(12'b0001_0000_0000, 3);
        chk("t6_key9", {22'd0, keypad}, 32'h00000200);
        do_frame(12'b0001_0000_0000);

        // Asynchronous clear while '9' is held
        repeat (6) @(negedge clock);
        clear = 1'b1;
        #1;
        chk("t6_clear_outs", {19'd0, keypad, star, hash, new_key}, 32'd0);
        chk("t6_clear_row", {28'd0, row_n}, 32'h0000000e);
        pressed = 12'd0;
        repeat (2) @(negedge clock);
        clear = 1'b0;
        model_reset();
        align();
        pulses = 0;
        for (int f = 1; f <= 4; f++) begin
            do_frame(12'b0001_0000_0000);
            if (f == 2) chk("t6_requalify_wait", {22'd0, keypad}, 32'd0);
        end
        frames(12'd0, 4);
        chk("t6_requalify_pulse", pulses, 32'd1);

        // Randomised frames against the reference model
        prev_m = 12'd0;
        for (int f = 0; f < 48; f++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom_range(0, 11);
            b   = $urandom_range(0, 11);
            if (sel < 5)      m = prev_m;
            else if (sel < 7) m = 12'd0;
            else if (sel < 9) m = 12'd1 << a;
            else              m = (12'd1 << a) | (12'd1 << b);
            do_frame(m);
            prev_m = m;
        end
        frames(12'd0, 4);
        chk("rand_idle", {19'd0, keypad, star, hash, new_key}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
